// File: rtl/led_color_router_pkg.sv
// Shared colour-mode encoding and default timing parameters for the LED colour router.
package led_color_router_pkg;

  localparam int unsigned MODE_W               = 2;
  localparam int unsigned DEFAULT_DEBOUNCE_CYC = 16;
  localparam int unsigned DEFAULT_NB_PWM       = 8;

  typedef enum logic [MODE_W-1:0] {
    MODE_GREEN = 2'b00,
    MODE_BLUE  = 2'b01,
    MODE_BOTH  = 2'b10,
    MODE_OFF   = 2'b11
  } mode_e;

  function automatic logic mode_g_on(input mode_e mode);
    return (mode == MODE_GREEN) || (mode == MODE_BOTH);
  endfunction

  function automatic logic mode_b_on(input mode_e mode);
    return (mode == MODE_BLUE) || (mode == MODE_BOTH);
  endfunction

endpackage

// File: rtl/led_color_router_sw_debounce.sv
// Two-flop synchronizer followed by a shared debounce counter over a vector of raw switches.
module led_color_router_sw_debounce #(
  parameter int unsigned WIDTH        = 3,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_i,
  output logic [WIDTH-1:0] sw_o
);

  localparam int unsigned   CntW   = $clog2(DEBOUNCE_CYC);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // Counter measures how long the synchronized vector has differed from the accepted value.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CntMax) begin
        deb_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sw_o = deb_q;

endmodule

// File: rtl/led_color_router.sv
// LED output stage: plain bank mirrors the pattern, RGB banks gated by a wrap-synchronous
// colour mode, with optional 25% PWM dimming on every bank.
module led_color_router
  import led_color_router_pkg::*;
#(
  parameter int unsigned NB_LED       = 4,
  parameter int unsigned NB_PWM       = DEFAULT_NB_PWM,
  parameter int unsigned DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NB_LED-1:0] i_pattern,
  input  logic              i_valid,
  input  logic [1:0]        i_sw_color,
  input  logic              i_sw_dim,
  output logic [NB_LED-1:0] o_led,
  output logic [NB_LED-1:0] o_led_g,
  output logic [NB_LED-1:0] o_led_b,
  output logic              o_wrap
);

  localparam logic [NB_PWM-1:0] DimOnCnt = NB_PWM'(1) << (NB_PWM - 2);

  logic [2:0]        sw_deb;
  mode_e             state_q, state_d;
  logic [NB_PWM-1:0] pwm_q;
  logic [NB_LED-1:0] led_q, led_d, led_g_q, led_g_d, led_b_q, led_b_d;
  logic              wrap_q, wrap_d;
  logic              en;

  led_color_router_sw_debounce #(
    .WIDTH        (3),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_sw_debounce (
    .clk  (clk),
    .rst  (rst),
    .sw_i ({i_sw_dim, i_sw_color}),
    .sw_o (sw_deb)
  );

  // Outputs gate on the current state, so the wrap pattern itself still shows the old colour.
  always_comb begin
    state_d = state_q;
    wrap_d  = i_valid && i_pattern[NB_LED-1];
    if (wrap_d) begin
      state_d = mode_e'(sw_deb[1:0]);
    end
    en      = !sw_deb[2] || (pwm_q < DimOnCnt);
    led_d   = en ? i_pattern : '0;
    led_g_d = (en && mode_g_on(state_q)) ? i_pattern : '0;
    led_b_d = (en && mode_b_on(state_q)) ? i_pattern : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MODE_GREEN;
      pwm_q   <= '0;
      led_q   <= '0;
      led_g_q <= '0;
      led_b_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pwm_q   <= pwm_q + 1'b1;
      led_q   <= led_d;
      led_g_q <= led_g_d;
      led_b_q <= led_b_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_led   = led_q;
  assign o_led_g = led_g_q;
  assign o_led_b = led_b_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_led_color_router.sv
// Scoreboard bench for led_color_router: directed scenarios plus random traffic vs. a queue model.
module tb_led_color_router;

  localparam int NbLed  = 4;
  localparam int NbPwm  = 8;
  localparam int DebCyc = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NbLed-1:0] i_pattern;
  logic             i_valid;
  logic [1:0]       i_sw_color;
  logic             i_sw_dim;
  logic [NbLed-1:0] o_led, o_led_g, o_led_b;
  logic             o_wrap;

  led_color_router #(
    .NB_LED       (NbLed),
    .NB_PWM       (NbPwm),
    .DEBOUNCE_CYC (DebCyc)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_pattern  (i_pattern),
    .i_valid    (i_valid),
    .i_sw_color (i_sw_color),
    .i_sw_dim   (i_sw_dim),
    .o_led      (o_led),
    .o_led_g    (o_led_g),
    .o_led_b    (o_led_b),
    .o_wrap     (o_wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NbLed-1:0] led;
    logic [NbLed-1:0] g;
    logic [NbLed-1:0] b;
    logic             wrap;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: switches seen two cycles late, accepted after DebCyc consecutive samples
  // that disagree with the accepted value; colour = accepted colour at the last wrap.
  logic [2:0] m_dly[$];
  logic [2:0] m_run[$];
  logic [2:0] m_acc;
  int         m_mode;
  int         m_cyc;

  logic [1:0] cur_c = 2'b00;
  logic       cur_d = 1'b0;

  task automatic step(input logic r, input logic [NbLed-1:0] p, input logic v);
    exp_t       e;
    logic       lit;
    logic [2:0] s;
    @(negedge clk);
    #1;
    rst        = r;
    i_pattern  = p;
    i_valid    = v;
    i_sw_color = cur_c;
    i_sw_dim   = cur_d;
    if (r) begin
      e = '0;
    end else begin
      lit    = !m_acc[2] || ((m_cyc % (1 << NbPwm)) < (1 << (NbPwm - 2)));
      e.led  = lit ? p : '0;
      e.g    = (lit && (m_mode == 0 || m_mode == 2)) ? p : '0;
      e.b    = (lit && (m_mode == 1 || m_mode == 2)) ? p : '0;
      e.wrap = v && p[NbLed-1];
    end
    exp_q.push_back(e);
    if (r) begin
      m_dly.delete();
      m_dly.push_back(3'b000);
      m_dly.push_back(3'b000);
      m_run.delete();
      m_acc  = 3'b000;
      m_mode = 0;
      m_cyc  = 0;
    end else begin
      if (v && p[NbLed-1]) m_mode = int'(m_acc[1:0]);
      s = m_dly.pop_front();
      m_dly.push_back({cur_d, cur_c});
      if (s != m_acc) begin
        m_run.push_back(s);
        if (m_run.size() == DebCyc) begin
          m_acc = s;
          m_run.delete();
        end
      end else begin
        m_run.delete();
      end
      m_cyc++;
    end
  endtask

  task automatic idle(input int n, input logic [NbLed-1:0] p);
    for (int i = 0; i < n; i++) step(1'b0, p, 1'b0);
  endtask

  // Monitor: every post-edge sample is a presented output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({o_led, o_led_g, o_led_b, o_wrap} !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got led=%b g=%b b=%b wrap=%b want led=%b g=%b b=%b wrap=%b",
                   $time, o_led, o_led_g, o_led_b, o_wrap, e.led, e.g, e.b, e.wrap);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with everything switched on.
    cur_c = 2'b11;
    cur_d = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 4'b0101, 1'b0);
    cur_c = 2'b00;
    cur_d = 1'b0;
    idle(4, 4'b0101);

    // Green -> blue at a wrap.
    cur_c = 2'b01;
    idle(20, 4'b0010);
    step(1'b0, 4'b0010, 1'b1);
    step(1'b0, 4'b1000, 1'b1);
    idle(3, 4'b0001);

    // Short glitch to BOTH is rejected; a long hold is accepted.
    cur_c = 2'b10;
    idle(10, 4'b0100);
    cur_c = 2'b01;
    idle(20, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b1000, 1'b1);
      idle(2, 4'b0001);
    end
    cur_c = 2'b10;
    idle(20, 4'b0010);
    step(1'b0, 4'b1000, 1'b1);
    idle(3, 4'b0011);

    // Dim: full PWM period and then some.
    cur_d = 1'b1;
    idle(20, 4'b1111);
    idle(300, 4'b1111);
    cur_d = 1'b0;
    idle(20, 4'b0110);

    // Accept OFF on the same edge as a wrap; the following wrap applies it.
    cur_c = 2'b11;
    step(1'b0, 4'b0001, 1'b0);
    idle(16, 4'b0001);
    step(1'b0, 4'b1000, 1'b1);
    idle(3, 4'b0101);
    step(1'b0, 4'b1001, 1'b1);
    idle(3, 4'b0101);

    // Reset in the middle of blue + dim.
    cur_c = 2'b01;
    cur_d = 1'b1;
    idle(20, 4'b0100);
    step(1'b0, 4'b1000, 1'b1);
    idle(5, 4'b0010);
    step(1'b1, 4'b0010, 1'b0);
    idle(25, 4'b0010);

    // Random traffic with slow switch activity and occasional glitches.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(99) < 3) cur_c = 2'($urandom_range(3));
      if ($urandom_range(99) < 2) cur_d = ~cur_d;
      step(($urandom_range(999) < 3), 4'($urandom_range(15)), ($urandom_range(99) < 30));
    end

    idle(2, 4'b0000);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
